// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell plus a borrow flop.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned     CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_c;
    logic             borrow_c;

    // Full-subtractor cell on the current LSBs
    assign bit_c    = a_q[0] ^ b_q[0] ^ borrow_q;
    assign borrow_c = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    cnt_d    = '0;
                    diff_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d   = {bit_c, diff_q[WIDTH-1:1]};
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = borrow_c;
                cnt_d    = cnt_q + CNT_W'(1);
                busy_d   = 1'b1;
                if (cnt_q == LAST) begin
                    // Overflow: borrow into the MSB differs from borrow out of it
                    bout_d  = borrow_c;
                    ovf_d   = borrow_q ^ borrow_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
endmodule
